alu_decode: RTL

Decode/issue stage that converts RV32I instructions into the 4-bit ALU opcode, register indices and immediate consumed by the execute-stage ALU. It is the producing end of the ALU opcode interface. It sits between instruction fetch and execute as a single registered pipeline stage with valid/ready handshakes on both sides and a synchronous flush for branch redirects.

---
 rtl/alu_pkg.sv | 86 ++++++++
 rtl/alu_decode_if.sv | 42 ++++
 rtl/alu_decode_comb.sv | 134 +++++++++++++
 rtl/alu_decode.sv | 62 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and bundle type for the RV32I decode/issue stage.
// Optional build macro: ALU_DECODE_ILLEGAL_TRAP_EN (see alu_decode_comb).
package alu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned OPC_W    = 7;

    // ALU opcodes consumed by the execute stage; 1011-1111 are never emitted
    localparam logic [ALU_OP_W-1:0] ALU_NONE = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1010;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

    localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
    localparam logic [F3_W-1:0] F3_SR      = 3'b101;
    localparam logic [F3_W-1:0] F3_OR      = 3'b110;
    localparam logic [F3_W-1:0] F3_AND     = 3'b111;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_opcode;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rd;
        logic [XLEN-1:0]     imm;
        logic                use_imm;
        logic                use_pc;
        logic                reg_write;
        logic                branch;
        logic                jump;
        logic                load;
        logic                store;
        logic [F3_W-1:0]     funct3;
        logic                illegal;
    } alu_bundle_t;

    // Shared OP/OP-IMM funct3 map; alt selects SUB/SRA
    function automatic logic [ALU_OP_W-1:0] alu_op_from_f3(input logic [F3_W-1:0] f3,
                                                            input logic alt);
        logic [ALU_OP_W-1:0] op;
        op = ALU_NONE;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: the decode stage; slave: the fetch/execute environment around it.
interface alu_decode_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_instr;
    logic [XLEN-1:0]     in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [ALU_OP_W-1:0] out_alu_opcode;
    logic [REG_W-1:0]    out_rs1;
    logic [REG_W-1:0]    out_rs2;
    logic [REG_W-1:0]    out_rd;
    logic [XLEN-1:0]     out_imm;
    logic                out_use_imm;
    logic                out_use_pc;
    logic                out_reg_write;
    logic                out_branch;
    logic                out_jump;
    logic                out_load;
    logic                out_store;
    logic [F3_W-1:0]     out_funct3;
    logic [XLEN-1:0]     out_pc;
    logic                out_illegal;

    modport master (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_opcode, out_rs1, out_rs2, out_rd, out_imm,
               out_use_imm, out_use_pc, out_reg_write, out_branch, out_jump, out_load,
               out_store, out_funct3, out_pc, out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_opcode, out_rs1, out_rs2, out_rd, out_imm,
               out_use_imm, out_use_pc, out_reg_write, out_branch, out_jump, out_load,
               out_store, out_funct3, out_pc, out_illegal
    );
endinterface

// File: rtl/alu_decode_comb.sv
// Pure combinational RV32I instruction -> ALU issue bundle decoder.
// ALU_DECODE_ILLEGAL_TRAP_EN: when defined, illegal encodings raise bundle.illegal.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output alu_bundle_t     bundle
);

    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  f3;
    logic [6:0]       f7;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
    logic             legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        bundle        = '0;
        bundle.rs1    = instr[19:15];
        bundle.rs2    = instr[24:20];
        bundle.rd     = instr[11:7];
        bundle.funct3 = f3;
        bundle.imm    = imm_i;
        legal         = 1'b1;

        case (opcode)
            OPC_OP: begin
                bundle.reg_write = 1'b1;
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == F3_ADD_SUB || f3 == F3_SR))) begin
                    bundle.alu_opcode = alu_op_from_f3(f3, f7[5]);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                bundle.reg_write = 1'b1;
                bundle.use_imm   = 1'b1;
                // Shift immediates reuse imm[11:5] as a funct7-like qualifier
                if (f3 == F3_SLL) begin
                    legal             = (f7 == 7'b0000000);
                    bundle.alu_opcode = ALU_SLL;
                end else if (f3 == F3_SR) begin
                    legal             = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    bundle.alu_opcode = alu_op_from_f3(f3, f7[5]);
                end else begin
                    bundle.alu_opcode = alu_op_from_f3(f3, 1'b0);
                end
            end
            OPC_LUI: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.rs1        = '0;
                bundle.imm        = imm_u;
                bundle.use_imm    = 1'b1;
                bundle.reg_write  = 1'b1;
            end
            OPC_AUIPC: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.imm        = imm_u;
                bundle.use_imm    = 1'b1;
                bundle.use_pc     = 1'b1;
                bundle.reg_write  = 1'b1;
            end
            OPC_JAL: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.imm        = imm_j;
                bundle.use_imm    = 1'b1;
                bundle.use_pc     = 1'b1;
                bundle.jump       = 1'b1;
                bundle.reg_write  = 1'b1;
            end
            OPC_JALR: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.use_imm    = 1'b1;
                bundle.jump       = 1'b1;
                bundle.reg_write  = 1'b1;
            end
            OPC_BRANCH: begin
                bundle.imm    = imm_b;
                bundle.branch = 1'b1;
                // BEQ/BNE resolve on the zero flag of SUB
                case (f3)
                    F3_BEQ, F3_BNE:   bundle.alu_opcode = ALU_SUB;
                    F3_BLT, F3_BGE:   bundle.alu_opcode = ALU_SLT;
                    F3_BLTU, F3_BGEU: bundle.alu_opcode = ALU_SLTU;
                    default:          legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.use_imm    = 1'b1;
                bundle.load       = 1'b1;
                bundle.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                bundle.alu_opcode = ALU_ADD;
                bundle.imm        = imm_s;
                bundle.use_imm    = 1'b1;
                bundle.store      = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings issue as an inert bundle; x0 is never written
        if (!legal) begin
            bundle.alu_opcode = ALU_NONE;
            bundle.use_imm    = 1'b0;
            bundle.use_pc     = 1'b0;
            bundle.reg_write  = 1'b0;
            bundle.branch     = 1'b0;
            bundle.jump       = 1'b0;
            bundle.load       = 1'b0;
            bundle.store      = 1'b0;
        end else if (bundle.rd == '0) begin
            bundle.reg_write = 1'b0;
        end

`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
        bundle.illegal = !legal;
`else
        bundle.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/alu_decode.sv
// Single registered decode/issue stage with valid/ready on both sides and flush.
// ALU_DECODE_ILLEGAL_TRAP_EN: when defined, out_illegal flags unsupported encodings.
module alu_decode
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    alu_decode_if.master  bus
);

    alu_bundle_t     dec_c;
    alu_bundle_t     bundle_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic            in_ready_c;
    logic            accept_c;

    alu_decode_comb u_comb (
        .instr  (bus.in_instr),
        .bundle (dec_c)
    );

    // Accept whenever the output slot is empty or being drained this cycle
    assign in_ready_c = !valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept_c) begin
            valid_q  <= 1'b1;
            bundle_q <= dec_c;
            pc_q     <= bus.in_pc;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = valid_q;
    assign bus.out_alu_opcode = bundle_q.alu_opcode;
    assign bus.out_rs1        = bundle_q.rs1;
    assign bus.out_rs2        = bundle_q.rs2;
    assign bus.out_rd         = bundle_q.rd;
    assign bus.out_imm        = bundle_q.imm;
    assign bus.out_use_imm    = bundle_q.use_imm;
    assign bus.out_use_pc     = bundle_q.use_pc;
    assign bus.out_reg_write  = bundle_q.reg_write;
    assign bus.out_branch     = bundle_q.branch;
    assign bus.out_jump       = bundle_q.jump;
    assign bus.out_load       = bundle_q.load;
    assign bus.out_store      = bundle_q.store;
    assign bus.out_funct3     = bundle_q.funct3;
    assign bus.out_pc         = pc_q;
    assign bus.out_illegal    = bundle_q.illegal;

endmodule
